// File: rtl/module_guess_game.sv
// Number-guessing game: capture a secret on Load, compare guesses on Enter,
// show |secret - guess| in hex on a multiplexed seven-segment display.
module module_guess_game #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned MAX_TRIES   = 5,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic [WIDTH-1:0]                 Input_R,
    input  logic [WIDTH-1:0]                 Input_D,
    input  logic                             Load,
    input  logic                             Enter,
    output logic [2:0]                       LEDs,
    output logic [NUM_DIGITS-1:0]            Display,
    output logic [7:0]                       Segments,
    output logic [$clog2(MAX_TRIES+1)-1:0]   Tries,
    output logic                             Playing,
    output logic                             Locked
);

    localparam int TRIES_W    = $clog2(MAX_TRIES + 1);
    localparam int HEX_DIGITS = (WIDTH + 3) / 4;
    localparam int CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StPlay, StWin, StLock} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   secret_q, secret_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic               neg_q, neg_d;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic [2:0]         leds_q, leds_d;
    logic               load_q, enter_q;
    logic [CNT_W-1:0]   refresh_q;
    logic [DIG_W-1:0]   digit_q;

    logic               load_rise, enter_rise;
    logic [WIDTH:0]     diff;
    logic [TRIES_W-1:0] tries_inc;
    logic [HEX_DIGITS*4-1:0] mag_ext;
    logic [3:0]         nibble;

    assign load_rise  = Load & ~load_q;
    assign enter_rise = Enter & ~enter_q;
    // One extra bit so the sign of secret - guess is never lost.
    assign diff       = {1'b0, secret_q} - {1'b0, Input_D};
    assign tries_inc  = tries_q + TRIES_W'(1);

    function automatic logic [7:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 8'hC0;
            4'h1: hex_glyph = 8'hF9;
            4'h2: hex_glyph = 8'hA4;
            4'h3: hex_glyph = 8'hB0;
            4'h4: hex_glyph = 8'h99;
            4'h5: hex_glyph = 8'h92;
            4'h6: hex_glyph = 8'h82;
            4'h7: hex_glyph = 8'hF8;
            4'h8: hex_glyph = 8'h80;
            4'h9: hex_glyph = 8'h90;
            4'hA: hex_glyph = 8'h88;
            4'hB: hex_glyph = 8'h83;
            4'hC: hex_glyph = 8'hC6;
            4'hD: hex_glyph = 8'hA1;
            4'hE: hex_glyph = 8'h86;
            default: hex_glyph = 8'h8E;
        endcase
    endfunction

    // Game state and datapath registers; edge registers reset high so held inputs don't fire.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            secret_q <= '0;
            mag_q    <= '0;
            neg_q    <= 1'b0;
            tries_q  <= '0;
            leds_q   <= 3'b000;
            load_q   <= 1'b1;
            enter_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            secret_q <= secret_d;
            mag_q    <= mag_d;
            neg_q    <= neg_d;
            tries_q  <= tries_d;
            leds_q   <= leds_d;
            load_q   <= Load;
            enter_q  <= Enter;
        end
    end

    // Next-state logic: Load wins over a simultaneous Enter; LOCK only exits on Reset.
    always_comb begin
        state_d  = state_q;
        secret_d = secret_q;
        mag_d    = mag_q;
        neg_d    = neg_q;
        tries_d  = tries_q;
        leds_d   = leds_q;
        unique case (state_q)
            StLock: begin
                leds_d = 3'b100;
            end
            default: begin
                if (load_rise) begin
                    secret_d = Input_R;
                    tries_d  = '0;
                    mag_d    = '0;
                    neg_d    = 1'b0;
                    leds_d   = 3'b000;
                    state_d  = StPlay;
                end else if (enter_rise && state_q == StPlay) begin
                    tries_d = tries_inc;
                    neg_d   = diff[WIDTH];
                    mag_d   = diff[WIDTH] ? (~diff[WIDTH-1:0] + WIDTH'(1)) : diff[WIDTH-1:0];
                    if (diff == '0) begin
                        leds_d  = 3'b001;
                        state_d = StWin;
                    end else begin
                        leds_d = diff[WIDTH] ? 3'b100 : 3'b010;
                        if (tries_inc == TRIES_W'(MAX_TRIES)) begin
                            leds_d  = 3'b100;
                            state_d = StLock;
                        end
                    end
                end
            end
        endcase
    end

    // Digit scan: refresh counter divides the clock, digit index advances on each wrap.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            refresh_q <= '0;
            digit_q   <= '0;
        end else if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_q <= '0;
            digit_q   <= (digit_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
        end else begin
            refresh_q <= refresh_q + CNT_W'(1);
        end
    end

    // Display drive: blank in IDLE, dash in LOCK, hex of Mag otherwise with sign on digit 0.
    always_comb begin
        Display  = '1;
        Segments = 8'hFF;
        mag_ext  = '0;
        mag_ext[WIDTH-1:0] = mag_q;
        nibble   = '0;
        for (int k = 0; k < HEX_DIGITS; k++) begin
            if (digit_q == DIG_W'(k)) nibble = mag_ext[4*k +: 4];
        end
        if (state_q != StIdle) begin
            Display[digit_q] = 1'b0;
            if (state_q == StLock) begin
                Segments = 8'hBF;
            end else if (int'(digit_q) < HEX_DIGITS) begin
                Segments = hex_glyph(nibble);
                if (digit_q == '0 && neg_q) Segments[7] = 1'b0;
            end
        end
    end

    assign LEDs    = (state_q == StLock) ? 3'b100 : leds_q;
    assign Tries   = tries_q;
    assign Playing = (state_q == StPlay);
    assign Locked  = (state_q == StLock);

endmodule
